// File: rtl/store_unit.sv
// Store buffer between execute and memory: formats sb/sh/sw into word-aligned
// lane-replicated writes, queues them in a small FIFO and rejects bad stores.
module store_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  output logic        st_misalign,
  output logic        st_illegal,
  output logic        busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic [29:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic [3:0]  strb_mem [DEPTH];

  logic        is_illegal;
  logic        is_misalign;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_wstrb;
  logic        accept;
  logic        push;
  logic        pop;

  // Decode the store width into lane data/strobes and classify bad requests.
  always_comb begin
    is_illegal  = 1'b0;
    is_misalign = 1'b0;
    fmt_wdata   = '0;
    fmt_wstrb   = '0;
    case (st_funct3)
      3'b000: begin
        fmt_wdata = {4{st_data[7:0]}};
        fmt_wstrb = 4'b0001 << st_addr[1:0];
      end
      3'b001: begin
        fmt_wdata   = {2{st_data[15:0]}};
        fmt_wstrb   = st_addr[1] ? 4'b1100 : 4'b0011;
        is_misalign = st_addr[0];
      end
      3'b010: begin
        fmt_wdata   = st_data;
        fmt_wstrb   = 4'b1111;
        is_misalign = |st_addr[1:0];
      end
      default: begin
        is_illegal = 1'b1;
      end
    endcase
  end

  assign st_ready = (count != FULL);
  assign busy     = (count != '0);
  assign mem_req  = busy;
  assign accept   = st_valid && st_ready;
  assign push     = accept && !is_illegal && !is_misalign;
  assign pop      = busy && mem_ack;

  // Head entry is presented only while something is buffered.
  assign mem_addr  = busy ? {addr_mem[rd_ptr], 2'b00} : '0;
  assign mem_wdata = busy ? data_mem[rd_ptr] : '0;
  assign mem_wstrb = busy ? strb_mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      st_misalign <= 1'b0;
      st_illegal  <= 1'b0;
    end else begin
      st_illegal  <= accept && is_illegal;
      st_misalign <= accept && !is_illegal && is_misalign;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      addr_mem[wr_ptr] <= st_addr[31:2];
      data_mem[wr_ptr] <= fmt_wdata;
      strb_mem[wr_ptr] <= fmt_wstrb;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_store_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic        st_misalign;
  logic        st_illegal;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } entry_t;

  entry_t exp_q[$];
  logic   exp_ill = 1'b0;
  logic   exp_mis = 1'b0;

  store_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
    .st_funct3(st_funct3), .st_addr(st_addr), .st_data(st_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .st_misalign(st_misalign),
    .st_illegal(st_illegal), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference formatting: a store of `size` bytes covers lanes off..off+size-1
  // and every lane carries the matching byte of the replicated data.
  function automatic entry_t model_format(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] d);
    entry_t e;
    int size;
    int off;
    size = 1 << f3;
    off = int'(a[1:0]);
    e.addr = a & 32'hFFFF_FFFC;
    e.wstrb = '0;
    e.wdata = '0;
    for (int lane = 0; lane < 4; lane++) begin
      e.wstrb[lane] = (lane >= off) && (lane < off + size);
      e.wdata[8*lane +: 8] = d[8*(lane % size) +: 8];
    end
    return e;
  endfunction

  // Drive one cycle of inputs, advance the model across the clock edge.
  task automatic step(input logic v, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, input logic ack);
    bit ready, do_pop, acc, ill, mis;
    int size;
    st_valid = v; st_funct3 = f3; st_addr = a; st_data = d; mem_ack = ack;
    ready  = exp_q.size() != DEPTH;
    do_pop = (exp_q.size() != 0) && ack;
    acc    = v && ready;
    ill    = acc && (f3 > 3'd2);
    size   = 1 << f3;
    mis    = acc && !ill && ((int'(a[1:0]) % size) != 0);
    @(posedge clk);
    if (do_pop) void'(exp_q.pop_front());
    if (acc && !ill && !mis) exp_q.push_back(model_format(f3, a, d));
    exp_ill = ill;
    exp_mis = mis;
    #1;
    st_valid = 1'b0;
    mem_ack  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; st_valid = 1'b0; mem_ack = 1'b0;
    st_funct3 = '0; st_addr = '0; st_data = '0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req got %0b want 0", mem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %0b want 0", busy); end
    checks++; if (st_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready got %0b want 1", st_ready); end
    checks++; if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin errors++; $display("[TB] FAIL rst_bus got %h/%h/%b want zeros", mem_addr, mem_wdata, mem_wstrb); end
    checks++; if ({st_misalign, st_illegal} !== 2'b00) begin errors++; $display("[TB] FAIL rst_flags got %b want 00", {st_misalign, st_illegal}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sb();
    step(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 1'b0);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL sb_req got %0b want 1", mem_req); end
    checks++; if (mem_addr !== 32'h0000_1000) begin errors++; $display("[TB] FAIL sb_addr got %h want 00001000", mem_addr); end
    checks++; if (mem_wdata !== 32'hA5A5_A5A5) begin errors++; $display("[TB] FAIL sb_wdata got %h want a5a5a5a5", mem_wdata); end
    checks++; if (mem_wstrb !== 4'b1000) begin errors++; $display("[TB] FAIL sb_wstrb got %b want 1000", mem_wstrb); end
    step(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL sb_drain got %0b want 0", busy); end
  endtask

  task automatic test_sh_misalign();
    step(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 1'b0);
    checks++; if (mem_addr !== 32'h0000_2000) begin errors++; $display("[TB] FAIL sh_addr got %h want 00002000", mem_addr); end
    checks++; if (mem_wdata !== 32'hBEEF_BEEF) begin errors++; $display("[TB] FAIL sh_wdata got %h want beefbeef", mem_wdata); end
    checks++; if (mem_wstrb !== 4'b1100) begin errors++; $display("[TB] FAIL sh_wstrb got %b want 1100", mem_wstrb); end
    step(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    step(1'b1, 3'b001, 32'h0000_2001, 32'h0000_BEEF, 1'b0);
    checks++; if (st_misalign !== 1'b1) begin errors++; $display("[TB] FAIL mis_pulse got %0b want 1", st_misalign); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL mis_req got %0b want 0", mem_req); end
    step(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    checks++; if (st_misalign !== 1'b0) begin errors++; $display("[TB] FAIL mis_width got %0b want 0", st_misalign); end
  endtask

  task automatic test_illegal();
    step(1'b1, 3'b011, 32'h0000_3001, 32'h1234_5678, 1'b0);
    checks++; if (st_illegal !== 1'b1) begin errors++; $display("[TB] FAIL ill_pulse got %0b want 1", st_illegal); end
    checks++; if (st_misalign !== 1'b0) begin errors++; $display("[TB] FAIL ill_prio got %0b want 0", st_misalign); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ill_enq got %0b want 0", busy); end
    step(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    checks++; if (st_illegal !== 1'b0) begin errors++; $display("[TB] FAIL ill_width got %0b want 0", st_illegal); end
  endtask

  task automatic test_back_pressure();
    step(1'b1, 3'b010, 32'h0000_0010, 32'h1111_1111, 1'b0);
    checks++; if (st_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready1 got %0b want 1", st_ready); end
    step(1'b1, 3'b010, 32'h0000_0014, 32'h2222_2222, 1'b0);
    checks++; if (st_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready2 got %0b want 0", st_ready); end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 3'b010, 32'h0000_0018, 32'h3333_3333, 1'b0);
      checks++; if (mem_addr !== 32'h10 || mem_wdata !== 32'h1111_1111 || mem_req !== 1'b1)
        begin errors++; $display("[TB] FAIL bp_hold got %h/%h/%0b want 00000010/11111111/1", mem_addr, mem_wdata, mem_req); end
    end
    step(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    checks++; if (mem_addr !== 32'h14 || mem_wdata !== 32'h2222_2222 || mem_wstrb !== 4'b1111)
      begin errors++; $display("[TB] FAIL bp_second got %h/%h/%b want 00000014/22222222/1111", mem_addr, mem_wdata, mem_wstrb); end
    step(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty got %0b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 3'b010, 32'h0000_0020, 32'hAAAA_0001, 1'b0);
    step(1'b1, 3'b000, 32'h0000_0025, 32'h0000_0077, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rm_fill got %0b want 1", busy); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rm_req got %0b want 0", mem_req); end
    checks++; if (st_ready !== 1'b1) begin errors++; $display("[TB] FAIL rm_ready got %0b want 1", st_ready); end
    checks++; if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin errors++; $display("[TB] FAIL rm_bus got %h/%h/%b want zeros", mem_addr, mem_wdata, mem_wstrb); end
    st_valid = 1'b1; st_funct3 = 3'b010; st_addr = 32'h40; st_data = 32'h5; mem_ack = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rm_ignore got %0b want 0", busy); end
    rst = 1'b0; st_valid = 1'b0; mem_ack = 1'b0;
    exp_q.delete(); exp_ill = 1'b0; exp_mis = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
      checks++; if (mem_req !== 1'b0 || st_ready !== 1'b1)
        begin errors++; $display("[TB] FAIL rm_after got req=%0b ready=%0b want 0/1", mem_req, st_ready); end
    end
  endtask

  task automatic test_random();
    entry_t head;
    logic [2:0] f3;
    for (int i = 0; i < 400; i++) begin
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      step($urandom_range(0, 2) != 0, f3, $urandom, $urandom, $urandom_range(0, 1) == 1);
      if (exp_q.size() != 0) head = exp_q[0];
      else begin head.addr = '0; head.wdata = '0; head.wstrb = '0; end
      checks++;
      if (mem_req !== (exp_q.size() != 0) || busy !== (exp_q.size() != 0) ||
          st_ready !== (exp_q.size() != DEPTH) || mem_addr !== head.addr ||
          mem_wdata !== head.wdata || mem_wstrb !== head.wstrb ||
          st_illegal !== exp_ill || st_misalign !== exp_mis) begin
        errors++;
        $display("[TB] FAIL rand_%0d got req=%0b rdy=%0b %h/%h/%b ill=%0b mis=%0b want req=%0b rdy=%0b %h/%h/%b ill=%0b mis=%0b",
                 i, mem_req, st_ready, mem_addr, mem_wdata, mem_wstrb, st_illegal, st_misalign,
                 exp_q.size() != 0, exp_q.size() != DEPTH, head.addr, head.wdata, head.wstrb, exp_ill, exp_mis);
      end
    end
    for (int i = 0; i < 2 * DEPTH && exp_q.size() != 0; i++) begin
      step(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rand_drain got %0b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_sh_misalign();
    test_illegal();
    test_back_pressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
